// File: rtl/hssi_tc_mailbox_bridge.sv
// Host CSR mailbox bridge to NUM_CH HSSI traffic-controller CSR slaves.
// Holds one command at a time and runs an Avalon-MM read/write against the selected port.
module hssi_tc_mailbox_bridge #(
  parameter  int NUM_CH      = 16,
  parameter  int TC_ADDR_W   = 16,
  parameter  int DATA_W      = 32,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     csr_wr,
  input  logic                     csr_rd,
  input  logic [3:0]               csr_addr,
  input  logic [DATA_W-1:0]        csr_wrdata,
  output logic [DATA_W-1:0]        csr_rddata,
  output logic                     csr_rdvalid,
  input  logic [CH_W-1:0]          port_sel,
  output logic [NUM_CH-1:0]        tc_read,
  output logic [NUM_CH-1:0]        tc_write,
  output logic [TC_ADDR_W-1:0]     tc_address,
  output logic [DATA_W-1:0]        tc_writedata,
  input  logic [NUM_CH-1:0]        tc_waitrequest,
  input  logic [NUM_CH*DATA_W-1:0] tc_readdata,
  input  logic [NUM_CH-1:0]        tc_readdatavalid
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, RD_WAIT, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  is_wr_reg;
  logic [CH_W-1:0]       ch_reg;
  logic [TC_ADDR_W-1:0]  addr_reg, tc_address_reg;
  logic [DATA_W-1:0]     wrdata_reg, rddata_reg, tc_writedata_reg, csr_rddata_reg;
  logic                  csr_rdvalid_reg;
  logic                  done_reg, timeout_err_reg, sel_err_reg, overrun_reg;

  logic [NUM_CH-1:0]     ch_onehot;
  logic                  sel_wait, sel_valid;
  logic [DATA_W-1:0]     sel_data, rd_mux;
  logic                  cmd_wr, accept, sel_bad, busy, capture, tmo;
  logic [1:0]            cmd;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_onehot[gi] = (ch_reg == CH_W'(gi));
    end
  endgenerate

  // Only the latched channel is observed; every other port is ignored.
  assign sel_wait  = |(tc_waitrequest & ch_onehot);
  assign sel_valid = |(tc_readdatavalid & ch_onehot);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_onehot[i]) sel_data = sel_data | tc_readdata[i*DATA_W +: DATA_W];
    end
  end

  assign cmd     = csr_wrdata[1:0];
  assign cmd_wr  = csr_wr && (csr_addr == 4'h0);
  assign accept  = cmd_wr && (state_reg == IDLE) && ((cmd == 2'd1) || (cmd == 2'd2));
  assign sel_bad = ({1'b0, port_sel} >= (CH_W+1)'(NUM_CH));
  assign busy    = (state_reg == REQ) || (state_reg == RD_WAIT);

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    tmo        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && !sel_bad) state_next = REQ;
      end
      REQ: begin
        // Completion is checked before the timeout so it wins on the last cycle.
        if (!sel_wait && is_wr_reg) begin
          state_next = DONE;
        end else if (!sel_wait && sel_valid) begin
          state_next = DONE;
          capture    = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
          tmo        = 1'b1;
        end else if (!sel_wait) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (sel_valid) begin
          state_next = DONE;
          capture    = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
          tmo        = 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (csr_addr)
      4'h0: rd_mux[6:0] = {overrun_reg, sel_err_reg, timeout_err_reg, done_reg, busy, 2'b00};
      4'h4: rd_mux[TC_ADDR_W-1:0] = addr_reg;
      4'h8: rd_mux = rddata_reg;
      4'hC: rd_mux = wrdata_reg;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      is_wr_reg        <= 1'b0;
      ch_reg           <= '0;
      addr_reg         <= '0;
      wrdata_reg       <= '0;
      rddata_reg       <= '0;
      tc_address_reg   <= '0;
      tc_writedata_reg <= '0;
      csr_rddata_reg   <= '0;
      csr_rdvalid_reg  <= 1'b0;
      done_reg         <= 1'b0;
      timeout_err_reg  <= 1'b0;
      sel_err_reg      <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      csr_rdvalid_reg <= csr_rd;
      if (csr_rd) csr_rddata_reg <= rd_mux;
      if (csr_wr && (csr_addr == 4'h4)) addr_reg <= csr_wrdata[TC_ADDR_W-1:0];
      if (csr_wr && (csr_addr == 4'hC)) wrdata_reg <= csr_wrdata;
      if (busy) cnt_reg <= cnt_reg + CNT_W'(1);

      if (accept) begin
        cnt_reg          <= '0;
        is_wr_reg        <= (cmd == 2'd2);
        ch_reg           <= port_sel;
        tc_address_reg   <= addr_reg;
        tc_writedata_reg <= wrdata_reg;
        done_reg         <= sel_bad;
        sel_err_reg      <= sel_bad;
        timeout_err_reg  <= 1'b0;
        overrun_reg      <= 1'b0;
      end else if (cmd_wr && (state_reg != IDLE)) begin
        // Any command arriving before the FSM is back in IDLE is dropped.
        overrun_reg <= 1'b1;
      end

      if (state_next == DONE) done_reg <= 1'b1;
      if (tmo) begin
        timeout_err_reg <= 1'b1;
        if (!is_wr_reg) rddata_reg <= '1;
      end
      if (capture) rddata_reg <= sel_data;
    end
  end

  // Requests decode from the async-reset state so they drop the moment rst_n falls.
  assign tc_read      = ((state_reg == REQ) && !is_wr_reg) ? ch_onehot : '0;
  assign tc_write     = ((state_reg == REQ) &&  is_wr_reg) ? ch_onehot : '0;
  assign tc_address   = tc_address_reg;
  assign tc_writedata = tc_writedata_reg;
  assign csr_rddata   = csr_rddata_reg;
  assign csr_rdvalid  = csr_rdvalid_reg;

endmodule

// File: tb/tb_hssi_tc_mailbox_bridge.sv
// Directed bench for hssi_tc_mailbox_bridge: CSR reads go through an expectation queue,
// traffic-controller pins are checked inline at each step.
module tb_hssi_tc_mailbox_bridge;

  localparam int NUM_CH      = 5;
  localparam int TC_ADDR_W   = 16;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;
  localparam int CH_W        = 3;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     csr_wr = 1'b0;
  logic                     csr_rd = 1'b0;
  logic [3:0]               csr_addr = '0;
  logic [DATA_W-1:0]        csr_wrdata = '0;
  logic [DATA_W-1:0]        csr_rddata;
  logic                     csr_rdvalid;
  logic [CH_W-1:0]          port_sel = '0;
  logic [NUM_CH-1:0]        tc_read;
  logic [NUM_CH-1:0]        tc_write;
  logic [TC_ADDR_W-1:0]     tc_address;
  logic [DATA_W-1:0]        tc_writedata;
  logic [NUM_CH-1:0]        tc_waitrequest = '0;
  logic [NUM_CH*DATA_W-1:0] tc_readdata = '0;
  logic [NUM_CH-1:0]        tc_readdatavalid = '0;

  hssi_tc_mailbox_bridge #(
    .NUM_CH(NUM_CH), .TC_ADDR_W(TC_ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .csr_wr(csr_wr), .csr_rd(csr_rd), .csr_addr(csr_addr),
    .csr_wrdata(csr_wrdata), .csr_rddata(csr_rddata), .csr_rdvalid(csr_rdvalid),
    .port_sel(port_sel), .tc_read(tc_read), .tc_write(tc_write), .tc_address(tc_address),
    .tc_writedata(tc_writedata), .tc_waitrequest(tc_waitrequest), .tc_readdata(tc_readdata),
    .tc_readdatavalid(tc_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rd_cycles = 0;
  int   wr_cycles = 0;
  int   rd_base, wr_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Request-cycle counters used to measure pulse widths.
  always @(negedge clk) begin
    rd_cycles = rd_cycles + $countones(tc_read);
    wr_cycles = wr_cycles + $countones(tc_write);
  end

  always @(negedge clk) begin
    if (rst_n && csr_rdvalid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL rdvalid_unrequested: observed 0x%08h expected no read", csr_rddata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] rd %s -> 0x%08h", e.tag, csr_rddata);
        check(e.tag, csr_rddata, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    $display("[TB] wr 0x%0h <= 0x%08h", a, d);
    csr_wr     = 1'b1;
    csr_addr   = a;
    csr_wrdata = d;
    tick();
    csr_wr = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, input logic [31:0] e, input string tag);
    csr_rd   = 1'b1;
    csr_addr = a;
    exp_q.push_back('{tag, e});
    tick();
    csr_rd = 1'b0;
    check({tag, "_rdvalid"}, 32'(csr_rdvalid), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    check("rst_tc_read", 32'(tc_read), 32'h0);
    check("rst_tc_write", 32'(tc_write), 32'h0);
    check("rst_rdvalid", 32'(csr_rdvalid), 32'h0);
    check("rst_tc_address", 32'(tc_address), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    csr_read(4'h0, 32'h0, "rst_cmd");
    csr_read(4'h4, 32'h0, "rst_addr");
    csr_read(4'h8, 32'h0, "rst_rddata");
    csr_read(4'hC, 32'h0, "rst_wrdata");

    // Read from channel 3; a stray valid on channel 1 must be ignored.
    csr_write(4'h4, 32'h100);
    port_sel = 3'd3;
    rd_base  = rd_cycles;
    csr_write(4'h0, 32'h1);
    check("rd_grant_read", 32'(tc_read), 32'h08);
    check("rd_grant_write", 32'(tc_write), 32'h0);
    check("rd_grant_addr", 32'(tc_address), 32'h100);
    tc_readdatavalid[1] = 1'b1;
    tc_readdata[1*DATA_W +: DATA_W] = 32'hBAD0;
    tick();
    tc_readdatavalid[1] = 1'b0;
    check("rd_wait_read_low", 32'(tc_read), 32'h0);
    csr_read(4'h0, 32'h4, "rd_busy");
    tick();
    tick();
    tc_readdatavalid[3] = 1'b1;
    tc_readdata[3*DATA_W +: DATA_W] = 32'h1234;
    tick();
    tc_readdatavalid[3] = 1'b0;
    csr_read(4'h0, 32'h8, "rd_done");
    csr_read(4'h8, 32'h1234, "rd_data");
    check("rd_pulse_cycles", 32'(rd_cycles - rd_base), 32'h1);

    // Write to channel 2 with three cycles of backpressure.
    csr_write(4'hC, 32'hCAFE);
    csr_write(4'h4, 32'h200);
    port_sel = 3'd2;
    tc_waitrequest[2] = 1'b1;
    wr_base = wr_cycles;
    csr_write(4'h0, 32'h2);
    for (int i = 0; i < 4; i++) begin
      check("wr_hold_write", 32'(tc_write), 32'h04);
      check("wr_hold_addr", 32'(tc_address), 32'h200);
      check("wr_hold_data", tc_writedata, 32'hCAFE);
      if (i == 3) tc_waitrequest[2] = 1'b0;
      tick();
    end
    check("wr_release", 32'(tc_write), 32'h0);
    check("wr_pulse_cycles", 32'(wr_cycles - wr_base), 32'h4);
    csr_read(4'h0, 32'h8, "wr_done");

    // Read from channel 0 that never answers.
    port_sel = 3'd0;
    csr_write(4'h0, 32'h1);
    repeat (TIMEOUT_CYC - 1) tick();
    csr_read(4'h0, 32'h4, "tmo_last_busy");
    csr_read(4'h0, 32'h18, "tmo_status");
    csr_read(4'h8, 32'hFFFF_FFFF, "tmo_rddata");
    csr_write(4'h8, 32'h0);
    csr_read(4'h8, 32'hFFFF_FFFF, "rddata_write_ignored");

    // Out-of-range port.
    port_sel = 3'd5;
    wr_base  = wr_cycles;
    csr_write(4'h0, 32'h2);
    check("sel_no_write", 32'(tc_write), 32'h0);
    tick();
    check("sel_no_write_later", 32'(tc_write), 32'h0);
    csr_read(4'h0, 32'h28, "sel_status");
    check("sel_pulse_cycles", 32'(wr_cycles - wr_base), 32'h0);

    // Command and register writes while a write is stalled.
    csr_write(4'hC, 32'h5555);
    csr_write(4'h4, 32'h10);
    port_sel = 3'd1;
    tc_waitrequest[1] = 1'b1;
    wr_base = wr_cycles;
    csr_write(4'h0, 32'h2);
    csr_write(4'h0, 32'h1);
    csr_write(4'h4, 32'h20);
    csr_write(4'hC, 32'h9999);
    check("ovr_write", 32'(tc_write), 32'h02);
    check("ovr_read_none", 32'(tc_read), 32'h0);
    check("ovr_addr", 32'(tc_address), 32'h10);
    check("ovr_data", tc_writedata, 32'h5555);
    csr_read(4'h0, 32'h44, "ovr_busy");
    tc_waitrequest[1] = 1'b0;
    tick();
    check("ovr_release", 32'(tc_write), 32'h0);
    check("ovr_pulse_cycles", 32'(wr_cycles - wr_base), 32'h5);
    csr_read(4'h0, 32'h48, "ovr_done");
    csr_read(4'h4, 32'h20, "ovr_addr_reg");
    csr_read(4'hC, 32'h9999, "ovr_wrdata_reg");

    // NOOP and code 3 in IDLE leave status untouched.
    csr_write(4'h0, 32'h0);
    csr_write(4'h0, 32'h3);
    check("noop_no_req", 32'(tc_read | tc_write), 32'h0);
    csr_read(4'h0, 32'h48, "noop_status");

    // Same-cycle write and read returns the old value.
    csr_wr     = 1'b1;
    csr_rd     = 1'b1;
    csr_addr   = 4'h4;
    csr_wrdata = 32'h77;
    exp_q.push_back('{"rw_same_cycle", 32'h20});
    tick();
    csr_wr = 1'b0;
    csr_rd = 1'b0;
    csr_read(4'h4, 32'h77, "rw_after");

    // Reset in the middle of a stalled read.
    port_sel = 3'd4;
    tc_waitrequest[4] = 1'b1;
    csr_write(4'h0, 32'h1);
    check("rstmid_grant", 32'(tc_read), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_read_drop", 32'(tc_read), 32'h0);
    check("rstmid_write_drop", 32'(tc_write), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tc_waitrequest = '0;
    tick();
    csr_read(4'h0, 32'h0, "rstmid_cmd");
    csr_read(4'h4, 32'h0, "rstmid_addr");
    check("rstmid_idle", 32'(tc_read | tc_write), 32'h0);

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
